// File: rtl/mario_motion_ctrl_if.sv
// Bundle between the motion sequencer and its neighbours: buttons, the
// position-register status/strobe bus, and the sprite-drawer handshake.
// master = sequencer side, slave = position register / drawer / buttons.
interface mario_motion_ctrl_if;
    // buttons
    logic go;
    logic right;
    logic left;
    logic up;
    logic down;
    // status from the position register
    logic ground;
    logic outofBounds;
    logic pipe;
    logic next;
    logic flag;
    logic dead;
    // drawer completion pulse
    logic draw_done;
    // strobes/levels to the position register
    logic start;
    logic lvl1;
    logic lvl2;
    logic lvl3;
    logic drStage1;
    logic drStage2;
    logic drStage3;
    logic erM;
    logic jumping;
    logic falling;
    // drawer requests and game status
    logic erase_req;
    logic draw_req;
    logic win;

    modport master (
        input  go, right, left, up, down,
        input  ground, outofBounds, pipe, next, flag, dead,
        input  draw_done,
        output start, lvl1, lvl2, lvl3,
        output drStage1, drStage2, drStage3,
        output erM, jumping, falling,
        output erase_req, draw_req, win
    );

    modport slave (
        output go, right, left, up, down,
        output ground, outofBounds, pipe, next, flag, dead,
        output draw_done,
        input  start, lvl1, lvl2, lvl3,
        input  drStage1, drStage2, drStage3,
        input  erM, jumping, falling,
        input  erase_req, draw_req, win
    );
endinterface

// File: rtl/mario_motion_ctrl.sv
// Game-flow and motion sequencer for the Mario position register.
// Paces motion to a frame tick, picks one move per frame, and brackets each
// move with an erase/redraw handshake to the sprite drawer.
module mario_motion_ctrl #(
    parameter int FRAME_DIV  = 833333,
    parameter int JUMP_STEPS = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    mario_motion_ctrl_if.master  bus
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [3:0] {
        S_START, S_CLR, S_LOAD, S_DRAW, S_WAIT,
        S_ERASE, S_STEP, S_COMMIT, S_WIN
    } state_t;

    typedef enum logic [1:0] {
        MV_NONE, MV_WALK, MV_JUMP, MV_FALL
    } mv_t;

    state_t          state, state_nxt;
    mv_t             mv, mv_nxt, mv_sel;
    logic [2:0]      lvl, lvl_nxt;          // lvl[0] = level 1, one-hot
    logic [7:0]      jump_cnt, jump_nxt, jump_sel;
    logic [FW-1:0]   frame_cnt;
    logic            frame_tick;

    // Out-of-bounds and down are handled inside the position register; this
    // block only carries them on the bus.
    logic unused_status;
    assign unused_status = bus.outofBounds ^ bus.down;

    assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));

    // Free-running frame divider, independent of the game state.
    always_ff @(posedge clk) begin
        if (reset)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    // Motion chosen for this frame: an unfinished jump wins, then gravity,
    // then a new jump from the ground, then a walk if exactly one of
    // right/left is pressed.
    always_comb begin
        mv_sel   = MV_NONE;
        jump_sel = jump_cnt;
        if (jump_cnt != 8'd0) begin
            mv_sel   = MV_JUMP;
            jump_sel = jump_cnt - 8'd1;
        end else if (!bus.ground) begin
            mv_sel = MV_FALL;
        end else if (bus.up) begin
            mv_sel   = MV_JUMP;
            jump_sel = 8'(JUMP_STEPS - 1);
        end else if (bus.right ^ bus.left) begin
            mv_sel = MV_WALK;
        end
    end

    // State, level, jump counter and latched move.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_START;
            lvl      <= 3'b001;
            jump_cnt <= 8'd0;
            mv       <= MV_NONE;
        end else begin
            state    <= state_nxt;
            lvl      <= lvl_nxt;
            jump_cnt <= jump_nxt;
            mv       <= mv_nxt;
        end
    end

    // Next-state and Moore outputs; every output defaults low.
    always_comb begin
        state_nxt    = state;
        lvl_nxt      = lvl;
        jump_nxt     = jump_cnt;
        mv_nxt       = mv;
        bus.start    = 1'b0;
        bus.drStage1 = 1'b0;
        bus.drStage2 = 1'b0;
        bus.drStage3 = 1'b0;
        bus.erM      = 1'b0;
        bus.jumping  = 1'b0;
        bus.falling  = 1'b0;
        bus.erase_req = 1'b0;
        bus.draw_req = 1'b0;
        bus.win      = 1'b0;
        case (state)
            S_START: begin
                bus.start = 1'b1;
                if (bus.go)
                    state_nxt = S_LOAD;
            end
            S_CLR: begin
                // one-cycle start pulse flushes stale pipe/next/flag/dead latches
                bus.start = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.drStage1 = lvl[0];
                bus.drStage2 = lvl[1];
                bus.drStage3 = lvl[2];
                state_nxt    = S_DRAW;
            end
            S_DRAW: begin
                bus.draw_req = 1'b1;
                if (bus.draw_done)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (frame_tick) begin
                    if (bus.dead) begin
                        lvl_nxt   = 3'b001;
                        jump_nxt  = 8'd0;
                        state_nxt = S_START;
                    end else if (bus.flag && lvl[2]) begin
                        state_nxt = S_WIN;
                    end else if (bus.pipe && lvl[0]) begin
                        lvl_nxt   = 3'b010;
                        jump_nxt  = 8'd0;
                        state_nxt = S_CLR;
                    end else if (bus.next && lvl[1]) begin
                        lvl_nxt   = 3'b100;
                        jump_nxt  = 8'd0;
                        state_nxt = S_CLR;
                    end else if (mv_sel != MV_NONE) begin
                        mv_nxt    = mv_sel;
                        jump_nxt  = jump_sel;
                        state_nxt = S_ERASE;
                    end
                end
            end
            S_ERASE: begin
                bus.erase_req = 1'b1;
                if (bus.draw_done)
                    state_nxt = S_STEP;
            end
            S_STEP: begin
                bus.erM     = (mv == MV_WALK);
                bus.jumping = (mv == MV_JUMP);
                bus.falling = (mv == MV_FALL);
                state_nxt   = S_COMMIT;
            end
            S_COMMIT: begin
                // idle cycle lets the position register fold the step into its base
                state_nxt = S_DRAW;
            end
            S_WIN: begin
                bus.win = 1'b1;
                if (bus.go) begin
                    lvl_nxt   = 3'b001;
                    state_nxt = S_START;
                end
            end
            default: begin
                state_nxt = S_START;
            end
        endcase
    end

    assign bus.lvl1 = lvl[0];
    assign bus.lvl2 = lvl[1];
    assign bus.lvl3 = lvl[2];

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Randomised bench for mario_motion_ctrl: drives the game through many frames
// with random status/buttons and checks every cycle's outputs against a
// frame-level model of levels, jump budget and the erase/step/draw sequence.
module tb_mario_motion_ctrl;

    localparam int FD      = 4;
    localparam int JS      = 3;
    localparam int NFRAMES = 300;

    localparam int M_NONE = 0;
    localparam int M_WALK = 1;
    localparam int M_JUMP = 2;
    localparam int M_FALL = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mario_motion_ctrl_if bus();

    mario_motion_ctrl #(.FRAME_DIV(FD), .JUMP_STEPS(JS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_lvl = 1;
    int m_jc  = 0;

    logic [12:0] obs;
    assign obs = {bus.start, bus.lvl1, bus.lvl2, bus.lvl3,
                  bus.drStage1, bus.drStage2, bus.drStage3,
                  bus.erM, bus.jumping, bus.falling,
                  bus.erase_req, bus.draw_req, bus.win};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected output vector for the current model level.
    function automatic logic [12:0] ev(bit st, bit ld, int mot, bit er, bit dr, bit w);
        logic [2:0] l;
        logic [2:0] m;
        l = (m_lvl == 1) ? 3'b100 : (m_lvl == 2) ? 3'b010 : 3'b001;
        m = (mot == M_WALK) ? 3'b100 : (mot == M_JUMP) ? 3'b010 :
            (mot == M_FALL) ? 3'b001 : 3'b000;
        return {st, l, (ld ? l : 3'b000), m, er, dr, w};
    endfunction

    // Frame-level motion rule; updates the jump budget.
    task automatic pick_motion(input bit ground, input bit up, input bit right,
                               input bit left, output int mot);
        mot = M_NONE;
        if (m_jc > 0) begin
            mot = M_JUMP;
            m_jc = m_jc - 1;
        end else if (!ground) begin
            mot = M_FALL;
        end else if (up) begin
            mot = M_JUMP;
            m_jc = JS - 1;
        end else if (right != left) begin
            mot = M_WALK;
        end
    endtask

    task automatic do_draw();
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            chk("draw_hold", obs, ev(0, 0, M_NONE, 0, 1, 0));
            tick();
        end
        chk("draw_hold", obs, ev(0, 0, M_NONE, 0, 1, 0));
        bus.draw_done = 1'b1;
        tick();
        bus.draw_done = 1'b0;
    endtask

    task automatic do_load();
        chk("load", obs, ev(0, 1, M_NONE, 0, 0, 0));
        tick();
        do_draw();
    endtask

    task automatic go_start();
        chk("start", obs, ev(1, 0, M_NONE, 0, 0, 0));
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        do_load();
    endtask

    // Idle in WAIT until the frame tick cycle, with stray draw_done noise,
    // then step across the decision edge.
    task automatic wait_frame(input bit noise);
        while (cyc % FD != FD - 1) begin
            chk("wait_idle", obs, ev(0, 0, M_NONE, 0, 0, 0));
            bus.draw_done = noise && ($urandom_range(0, 3) == 0);
            tick();
            bus.draw_done = 1'b0;
        end
        chk("wait_idle", obs, ev(0, 0, M_NONE, 0, 0, 0));
        tick();
    endtask

    task automatic do_motion(input int mot);
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            chk("erase_hold", obs, ev(0, 0, M_NONE, 1, 0, 0));
            tick();
        end
        chk("erase_hold", obs, ev(0, 0, M_NONE, 1, 0, 0));
        bus.draw_done = 1'b1;
        tick();
        bus.draw_done = 1'b0;
        chk("step", obs, ev(0, 0, mot, 0, 0, 0));
        tick();
        chk("commit", obs, ev(0, 0, M_NONE, 0, 0, 0));
        tick();
        do_draw();
    endtask

    task automatic do_win();
        int k;
        chk("win", obs, ev(0, 0, M_NONE, 0, 0, 1));
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
            tick();
            chk("win_hold", obs, ev(0, 0, M_NONE, 0, 0, 1));
        end
        bus.go = 1'b1;
        tick();
        m_lvl = 1;
        chk("win_restart", obs, ev(1, 0, M_NONE, 0, 0, 0));
        tick();
        bus.go = 1'b0;
        do_load();
    endtask

    task automatic do_frame();
        bit dead, flag, pipe, nxt, ground, up, right, left;
        int mot;
        dead   = ($urandom_range(0, 15) == 0);
        flag   = ($urandom_range(0, 3) == 0);
        pipe   = ($urandom_range(0, 3) == 0);
        nxt    = ($urandom_range(0, 3) == 0);
        ground = ($urandom_range(0, 3) != 0);
        up     = ($urandom_range(0, 3) == 0);
        right  = 1'($urandom_range(0, 1));
        left   = 1'($urandom_range(0, 1));
        bus.dead = dead; bus.flag = flag; bus.pipe = pipe; bus.next = nxt;
        bus.ground = ground; bus.up = up; bus.right = right; bus.left = left;
        bus.down = 1'($urandom_range(0, 1));
        bus.outofBounds = 1'($urandom_range(0, 1));
        wait_frame(1'b1);
        if (dead) begin
            m_lvl = 1;
            m_jc  = 0;
            go_start();
        end else if (flag && m_lvl == 3) begin
            do_win();
        end else if ((pipe && m_lvl == 1) || (nxt && m_lvl == 2)) begin
            m_lvl = m_lvl + 1;
            m_jc  = 0;
            chk("clr", obs, ev(1, 0, M_NONE, 0, 0, 0));
            tick();
            do_load();
        end else begin
            pick_motion(ground, up, right, left, mot);
            if (mot != M_NONE)
                do_motion(mot);
        end
    endtask

    initial begin
        bus.go = 0; bus.right = 0; bus.left = 0; bus.up = 0; bus.down = 0;
        bus.ground = 1; bus.outofBounds = 0; bus.pipe = 0; bus.next = 0;
        bus.flag = 0; bus.dead = 0; bus.draw_done = 0;
        reset = 1'b1;
        tick();
        tick();
        chk("reset", obs, ev(1, 0, M_NONE, 0, 0, 0));
        reset = 1'b0;
        cyc = 0;
        tick();
        chk("start_hold", obs, ev(1, 0, M_NONE, 0, 0, 0));
        go_start();

        for (int f = 0; f < NFRAMES; f++)
            do_frame();

        // Walk request, then reset while erase_req is pending.
        bus.dead = 0; bus.flag = 0; bus.pipe = 0; bus.next = 0;
        bus.ground = 1; bus.up = 0; bus.right = 1; bus.left = 0;
        wait_frame(1'b0);
        chk("erase_pre", obs, ev(0, 0, M_NONE, 1, 0, 0));
        reset = 1'b1;
        tick();
        m_lvl = 1;
        chk("reset_mid", obs, ev(1, 0, M_NONE, 0, 0, 0));
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mario_motion_ctrl.md
Name: mario_motion_ctrl

Overview:
- Game-flow and motion sequencer that sits directly upstream of the Mario position register.
- Generates the level-select, stage-load, start, move/jump/fall strobes that the position register consumes.
- Consumes the ground, outofBounds, pipe, next, flag and dead status the position register produces.
- Paces all motion to a frame tick and handshakes with the VGA sprite drawer (erase, then redraw each frame).

Parameters:
- FRAME_DIV, 833333, clk cycles per motion frame (60 Hz at 50 MHz); minimum 4.
- JUMP_STEPS, 24, frames of upward motion per jump; 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  start/restart button, level-sensitive, already synchronised
- right, left, up, down  in  1 each  direction buttons (up = jump request)
- ground, outofBounds, pipe, next, flag, dead  in  1 each  status from position register
- draw_done  in  1  one-cycle pulse from sprite drawer when the requested erase/draw completes
- start  out  1  clears position-register latches
- lvl1, lvl2, lvl3  out  1 each  one-hot current level
- drStage1, drStage2, drStage3  out  1 each  one-cycle stage-load strobes
- erM, jumping, falling  out  1 each  one-cycle motion strobes (mutually exclusive)
- erase_req, draw_req  out  1 each  drawer requests, held until draw_done
- win  out  1  high in WIN state

Behaviour:
- Reset: state=START; start=1; lvl1=1, lvl2=lvl3=0; all strobes, reqs and win = 0; frame_cnt=0; jump_cnt=0.
- frame_cnt counts 0..FRAME_DIV-1 and wraps; frame_tick=1 on the wrap cycle. Counter runs in every state and resets only on reset.
- States and transitions:
  - START: start=1; current lvl held. On go=1 -> LOAD.
  - CLR: start=1 for exactly 1 cycle -> LOAD. Used on every level change so the position register's stale pipe/next/flag/dead latches clear.
  - LOAD: drStageN=1 for 1 cycle, N = current level -> DRAW.
  - DRAW: draw_req=1 until draw_done; then -> WAIT.
  - WAIT: nothing asserted until frame_tick, then decide in that same cycle, first match wins:
    1. dead -> lvl1, jump_cnt=0 -> START.
    2. flag and lvl3 -> WIN.
    3. pipe and lvl1 -> lvl2, jump_cnt=0 -> CLR.
    4. next and lvl2 -> lvl3, jump_cnt=0 -> CLR.
    5. Otherwise, if a motion is pending (below) -> ERASE; if none, stay in WAIT.
  - Motion selection, latched as mv in WAIT:
    - jump_cnt>0 -> JUMP, jump_cnt decrements.
    - Else ground=0 -> FALL.
    - Else up=1 and ground=1 -> JUMP, jump_cnt=JUMP_STEPS-1.
    - Else right XOR left -> WALK.
    - Else none. right=left=1 is none.
  - ERASE: erase_req=1 until draw_done -> STEP.
  - STEP: exactly one of erM (WALK), jumping (JUMP), falling (FALL) for 1 cycle -> COMMIT.
  - COMMIT: 1 idle cycle so the position register copies update into its base position -> DRAW.
  - WIN: win=1; on go=1 -> lvl1 -> START. go is level-sensitive, so START then advances on the next go sample.
- While up is held, right/left are not consumed here; the position register reads them directly during jumping/falling.
- JUMP with ground=1 mid-jump (ceiling/platform) does not abort; jump_cnt runs out and FALL follows.
- erase_req and draw_req are never high together. draw_done outside ERASE/DRAW is ignored.
- lvl outputs change only on the CLR/START/WIN transitions listed above; exactly one is high at all times.
- Reset asserted mid-operation (any state, requests pending) returns to the reset values on the next clk edge.

Test Plan:
- Reset 2 cycles, go=1 -> start=1 during START; then drStage1 high for exactly 1 cycle with lvl1=1; draw_req held until draw_done pulse.
- FRAME_DIV=4, ground=1, right=1 -> per frame: erase_req, draw_done, then erM for 1 cycle, 1 idle cycle, draw_req; no jumping/falling.
- ground=1, up=1 at frame, JUMP_STEPS=3 -> jumping strobes on 3 consecutive frames, then falling each frame until ground=1.
- lvl1, pipe=1 at frame_tick -> lvl2=1, start high for 1 cycle, then drStage2 for 1 cycle; repeat with lvl2 and next=1 -> lvl3.
- dead=1 and flag=1 together in lvl3 -> START with lvl1=1 (dead priority); separately flag=1 -> win=1, go -> START, lvl1.
- Reset asserted during ERASE with erase_req=1 -> next cycle erase_req=0, start=1, lvl1=1.
